// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IF/MEM backing-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_DATA  = 1'b0,
        OWN_FETCH = 1'b1
    } arb_owner_t;

    localparam int STARVE_MAX_DEF = 4;
    // Wide enough for the largest legal STARVE_MAX (15).
    localparam int STARVE_CNT_W   = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while a fetch was waiting.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam logic [STARVE_CNT_W-1:0] MAX_V = STARVE_CNT_W'(MAX);

    logic [STARVE_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX_V)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_max = (r_cnt == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack backing memory between the fetch and data ports,
// data first, with a starvation limit that eventually forces a fetch.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    arb_owner_t        r_owner;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_if_ack;
    logic              r_dm_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic w_idle;
    logic w_at_max;
    logic w_grant_fetch;
    logic w_grant_data;
    logic w_cnt_inc;
    logic w_cnt_clr;

    assign w_idle        = (r_state == IDLE);
    // Fetch wins only when alone or when data has hit the starvation limit.
    assign w_grant_fetch = w_idle && if_req && (!dm_req || w_at_max);
    assign w_grant_data  = w_idle && dm_req && !w_grant_fetch;
    assign w_cnt_inc     = w_grant_data && if_req;
    assign w_cnt_clr     = w_grant_fetch || (w_grant_data && !if_req);

    arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .i_inc    (w_cnt_inc),
        .i_clr    (w_cnt_clr),
        .o_at_max (w_at_max)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= OWN_DATA;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_fetch) begin
                        r_owner    <= OWN_FETCH;
                        r_mem_addr <= if_addr;
                        r_mem_we   <= 1'b0;
                        r_mem_req  <= 1'b1;
                        r_state    <= ISSUE;
                    end else if (w_grant_data) begin
                        r_owner     <= OWN_DATA;
                        r_mem_addr  <= dm_addr;
                        r_mem_we    <= dm_we;
                        r_mem_wdata <= dm_wdata;
                        r_mem_req   <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (r_owner == OWN_FETCH) begin
                            r_if_rdata <= mem_rdata;
                            r_if_ack   <= 1'b1;
                        end else begin
                            // Stores leave the last load data visible.
                            if (!r_mem_we) begin
                                r_dm_rdata <= mem_rdata;
                            end
                            r_dm_ack <= 1'b1;
                        end
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_if_ack <= 1'b0;
                    r_dm_ack <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_if_ack  <= 1'b0;
                    r_dm_ack  <= 1'b0;
                    r_mem_req <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ack    = r_if_ack;
    assign dm_ack    = r_dm_ack;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port backing memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage load/store).
- Sits between the pipeline stage ports and the unified memory.
- Sequences one transaction at a time over a variable-latency req/ack memory interface.
- Data port has priority; a starvation counter guarantees instruction-fetch progress.
- Pipeline stall logic derives from pending-request-without-ack.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_MAX, 4, consecutive data grants while fetch waits before fetch is forced (range 1..15)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_W  fetch address, stable while if_req
if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  out  DATA_W  fetched instruction word (registered)
dm_req  in  1  data request, held until dm_ack
dm_we  in  1  1=store, 0=load; stable while dm_req
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_ack  out  1  one-cycle pulse: data access complete
dm_rdata  out  DATA_W  load data (registered)
mem_req  out  1  backing-memory request, held until mem_ack
mem_we  out  1  backing-memory write enable
mem_addr  out  ADDR_W  backing-memory address
mem_wdata  out  DATA_W  backing-memory write data
mem_ack  in  1  one-cycle completion from memory; mem_rdata valid same cycle
mem_rdata  in  DATA_W  backing-memory read data

Behaviour:
- Reset values (async, immediate):
  - state=IDLE, owner=DATA, starve_cnt=0.
  - mem_req, mem_we, if_ack, dm_ack = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If neither req: stay.
  - Only one req: grant it.
  - Both req: grant DATA, unless starve_cnt==STARVE_MAX, then grant FETCH.
  - On grant, register mem_addr/mem_we/mem_wdata from the winner (mem_we=0 for fetch), set owner, mem_req=1, go ISSUE.
- ISSUE:
  - Hold mem_req and all mem_* outputs stable.
  - On mem_ack: mem_req=0 next cycle; capture mem_rdata into owner's rdata register (loads and fetches only; stores leave dm_rdata unchanged); go RESP.
- RESP:
  - Assert owner's ack for exactly this cycle.
  - No arbitration in RESP (requester still holds req this cycle); always return to IDLE.
- Latency: req seen in IDLE at cycle t -> mem_req high at t+1 -> mem_ack at t+1+L (L>=0, mem_ack may coincide with first mem_req cycle) -> ack at t+2+L.
  - Back-to-back throughput is one transaction per L+3 cycles.
- starve_cnt, evaluated at each IDLE grant:
  - DATA granted while if_req=1: increment, saturating at STARVE_MAX.
  - FETCH granted, or if_req=0: clear to 0.
- mem_ack outside ISSUE is ignored.
- if_ack and dm_ack are never high together.
- Requester dropping req before its ack: not permitted (protocol violation); the transaction still completes and the ack still pulses.
- Reset during ISSUE abandons the memory transaction. mem_req drops asynchronously; the memory is required to discard it.
- Address/data pass through unmodified; no alignment checks (handled upstream).

Decomposition:
- Shared package `mem_arb_pkg`:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2);
  - owner encoding (OWN_DATA=1'b0, OWN_FETCH=1'b1);
  - default STARVE_MAX.
- One natural sub-module: `arb_starve_ctr` (saturating counter with inc/clr, compare-equal output).
- FSM and port muxing stay in the top.

Test Plan:
1. Reset: after reset, all outputs are 0. Then if_req=1, if_addr=0x0000_0010; memory acks with L=2 and mem_rdata=0x2010_0005 -> mem_req rises at cycle 1 with mem_addr=0x10, mem_we=0; if_ack pulses one cycle at cycle 4 with if_rdata=0x2010_0005.
2. Simultaneous: if_req and dm_req (load 0x100) asserted together -> data granted first; mem_addr=0x100, dm_ack pulses, dm_rdata=mem_rdata; the fetch is granted at the next IDLE; if_ack follows.
3. Store: dm_req, dm_we=1, dm_addr=0x200, dm_wdata=0xDEAD_BEEF -> mem_we=1 with matching address and data; dm_ack pulses; dm_rdata keeps its previous value.
4. Starvation: dm_req held high continuously with if_req high, STARVE_MAX=4 -> exactly 4 data grants, then the fetch is granted; starve_cnt returns to 0; data is granted next.
5. Zero-latency memory: mem_ack in the same cycle mem_req rises -> ack 2 cycles after req; requester holds req through the RESP cycle -> no duplicate grant, exactly one mem_req per request.
6. Reset mid-ISSUE: assert reset while mem_req=1 -> mem_req drops asynchronously; no ack pulses; the next request after deassertion completes normally.
